// File: rtl/placar_datapath.sv
// Truco score datapath: hand points and tentos for both teams, equality flags
// for the score controller, registered BCD digits and a sticky command-error flag.
module placar_datapath #(
  parameter int unsigned PONTOS_MAX = 12,
  parameter int unsigned TENTOS_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_pa,
  input  logic       clear_pa,
  input  logic       load_ta,
  input  logic       clear_ta,
  input  logic       load_pb,
  input  logic       clear_pb,
  input  logic       load_tb,
  input  logic       clear_tb,
  input  logic       fim_jogo,
  input  logic [3:0] valor_mao,
  output logic [3:0] pontos_a,
  output logic [3:0] pontos_b,
  output logic [1:0] tentos_a,
  output logic [1:0] tentos_b,
  output logic       a_igual12,
  output logic       b_igual12,
  output logic       ta_igual3,
  output logic       tb_igual3,
  output logic [3:0] pa_dez,
  output logic [3:0] pa_uni,
  output logic [3:0] pb_dez,
  output logic [3:0] pb_uni,
  output logic       erro_cmd
);

  localparam logic [3:0] P_MAX = 4'(PONTOS_MAX);
  localparam logic [1:0] T_MAX = 2'(TENTOS_MAX);

  logic [3:0] valor_ef;
  logic [3:0] pa_next, pb_next;
  logic [1:0] ta_next, tb_next;
  logic       erro_next;

  // Sum in 5 bits so a 12 + 12 never wraps before the saturation compare.
  function automatic logic [3:0] soma_pontos(input logic [3:0] atual, input logic [3:0] v);
    logic [4:0] s;
    s = {1'b0, atual} + {1'b0, v};
    if (s > {1'b0, P_MAX}) return P_MAX;
    return s[3:0];
  endfunction

  function automatic logic [1:0] soma_tento(input logic [1:0] atual);
    if (atual >= T_MAX) return T_MAX;
    return atual + 2'd1;
  endfunction

  function automatic logic [7:0] para_bcd(input logic [3:0] v);
    if (v >= 4'd10) return {4'd1, v - 4'd10};
    return {4'd0, v};
  endfunction

  always_comb begin
    valor_ef = valor_mao;
    if (valor_mao == 4'd0)
      valor_ef = 4'd1;
    else if (valor_mao > P_MAX)
      valor_ef = P_MAX;
  end

  // Clear beats load; loads are frozen once the game is over.
  always_comb begin
    pa_next = pontos_a;
    pb_next = pontos_b;
    ta_next = tentos_a;
    tb_next = tentos_b;

    if (clear_pa)                 pa_next = 4'd0;
    else if (load_pa && !fim_jogo) pa_next = soma_pontos(pontos_a, valor_ef);

    if (clear_pb)                 pb_next = 4'd0;
    else if (load_pb && !fim_jogo) pb_next = soma_pontos(pontos_b, valor_ef);

    if (clear_ta)                 ta_next = 2'd0;
    else if (load_ta && !fim_jogo) ta_next = soma_tento(tentos_a);

    if (clear_tb)                 tb_next = 2'd0;
    else if (load_tb && !fim_jogo) tb_next = soma_tento(tentos_b);
  end

  always_comb begin
    erro_next = erro_cmd
              | (load_pa & load_pb)
              | (load_ta & load_tb)
              | (load_pa & clear_pa)
              | (load_pb & clear_pb)
              | (load_ta & clear_ta)
              | (load_tb & clear_tb);
  end

  // Flags and digits come from the next values so they line up with the registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pontos_a  <= 4'd0;
      pontos_b  <= 4'd0;
      tentos_a  <= 2'd0;
      tentos_b  <= 2'd0;
      a_igual12 <= 1'b0;
      b_igual12 <= 1'b0;
      ta_igual3 <= 1'b0;
      tb_igual3 <= 1'b0;
      pa_dez    <= 4'd0;
      pa_uni    <= 4'd0;
      pb_dez    <= 4'd0;
      pb_uni    <= 4'd0;
      erro_cmd  <= 1'b0;
    end else begin
      pontos_a  <= pa_next;
      pontos_b  <= pb_next;
      tentos_a  <= ta_next;
      tentos_b  <= tb_next;
      a_igual12 <= (pa_next == P_MAX);
      b_igual12 <= (pb_next == P_MAX);
      ta_igual3 <= (ta_next == T_MAX);
      tb_igual3 <= (tb_next == T_MAX);
      {pa_dez, pa_uni} <= para_bcd(pa_next);
      {pb_dez, pb_uni} <= para_bcd(pb_next);
      erro_cmd  <= erro_next;
    end
  end

endmodule

// File: tb/tb_placar_datapath.sv
// Directed bench for placar_datapath with hand-computed expectations.
module tb_placar_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_pa, clear_pa, load_ta, clear_ta;
  logic       load_pb, clear_pb, load_tb, clear_tb;
  logic       fim_jogo;
  logic [3:0] valor_mao;
  logic [3:0] pontos_a, pontos_b;
  logic [1:0] tentos_a, tentos_b;
  logic       a_igual12, b_igual12, ta_igual3, tb_igual3;
  logic [3:0] pa_dez, pa_uni, pb_dez, pb_uni;
  logic       erro_cmd;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  placar_datapath dut (
    .clk(clk), .reset(reset),
    .load_pa(load_pa), .clear_pa(clear_pa), .load_ta(load_ta), .clear_ta(clear_ta),
    .load_pb(load_pb), .clear_pb(clear_pb), .load_tb(load_tb), .clear_tb(clear_tb),
    .fim_jogo(fim_jogo), .valor_mao(valor_mao),
    .pontos_a(pontos_a), .pontos_b(pontos_b), .tentos_a(tentos_a), .tentos_b(tentos_b),
    .a_igual12(a_igual12), .b_igual12(b_igual12), .ta_igual3(ta_igual3), .tb_igual3(tb_igual3),
    .pa_dez(pa_dez), .pa_uni(pa_uni), .pb_dez(pb_dez), .pb_uni(pb_uni),
    .erro_cmd(erro_cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_pa = 0; clear_pa = 0; load_ta = 0; clear_ta = 0;
    load_pb = 0; clear_pb = 0; load_tb = 0; clear_tb = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pa"},   32'(pontos_a), 0);
    check({tag, "_pb"},   32'(pontos_b), 0);
    check({tag, "_ta"},   32'(tentos_a), 0);
    check({tag, "_tb"},   32'(tentos_b), 0);
    check({tag, "_flags"}, 32'({a_igual12, b_igual12, ta_igual3, tb_igual3}), 0);
    check({tag, "_bcd"},  32'({pa_dez, pa_uni, pb_dez, pb_uni}), 0);
    check({tag, "_erro"}, 32'(erro_cmd), 0);
  endtask

  initial begin
    reset = 1; fim_jogo = 0; valor_mao = 0;
    idle();
    repeat (2) @(posedge clk);
    #3 reset = 0;
    tick();
    check_all_zero("rst_init");

    // Build pontos_a = 7, then reset asynchronously mid-cycle
    valor_mao = 7; load_pa = 1; tick(); idle();
    check("pa_7", 32'(pontos_a), 7);
    check("pa_7_uni", 32'(pa_uni), 7);
    #2 reset = 1;
    #1 check_all_zero("rst_async");
    @(negedge clk) reset = 0;
    tick();
    check_all_zero("rst_release");

    // Four loads of 3: 3, 6, 9, 12
    valor_mao = 3;
    load_pa = 1; tick(); idle(); check("pa_3", 32'(pontos_a), 3);
    load_pa = 1; tick(); idle(); check("pa_6", 32'(pontos_a), 6);
    load_pa = 1; tick(); idle(); check("pa_9", 32'(pontos_a), 9);
    check("pa_9_flag", 32'(a_igual12), 0);
    check("pa_9_bcd", 32'({pa_dez, pa_uni}), 32'h09);
    load_pa = 1; tick(); idle(); check("pa_12", 32'(pontos_a), 12);
    check("pa_12_flag", 32'(a_igual12), 1);
    check("pa_12_bcd", 32'({pa_dez, pa_uni}), 32'h12);

    // Team B: 10, then +6 saturates, then valor 0 (as 1) stays 12
    valor_mao = 10; load_pb = 1; tick(); idle();
    check("pb_10", 32'(pontos_b), 10);
    check("pb_10_bcd", 32'({pb_dez, pb_uni}), 32'h10);
    check("pb_10_flag", 32'(b_igual12), 0);
    valor_mao = 6; load_pb = 1; tick(); idle();
    check("pb_sat", 32'(pontos_b), 12);
    check("pb_sat_flag", 32'(b_igual12), 1);
    valor_mao = 0; load_pb = 1; tick(); idle();
    check("pb_hold12", 32'(pontos_b), 12);

    // valor_mao mapping from zero: 0 -> 1, 15 -> 12
    clear_pb = 1; tick(); idle();
    check("pb_clr", 32'(pontos_b), 0);
    check("pb_clr_flag", 32'(b_igual12), 0);
    valor_mao = 0; load_pb = 1; tick(); idle();
    check("pb_v0", 32'(pontos_b), 1);
    clear_pb = 1; tick(); idle();
    valor_mao = 15; load_pb = 1; tick(); idle();
    check("pb_v15", 32'(pontos_b), 12);
    check("pb_v15_bcd", 32'({pb_dez, pb_uni}), 32'h12);

    // tentos_a to 2, then combined clear_pa + clear_pb + load_ta
    load_ta = 1; tick(); idle(); check("ta_1", 32'(tentos_a), 1);
    load_ta = 1; tick(); idle(); check("ta_2", 32'(tentos_a), 2);
    check("ta_2_flag", 32'(ta_igual3), 0);
    clear_pa = 1; clear_pb = 1; load_ta = 1; tick(); idle();
    check("combo_pa", 32'(pontos_a), 0);
    check("combo_pb", 32'(pontos_b), 0);
    check("combo_ta", 32'(tentos_a), 3);
    check("combo_ta_flag", 32'(ta_igual3), 1);
    check("combo_a_flag", 32'(a_igual12), 0);
    check("combo_bcd", 32'({pa_dez, pa_uni, pb_dez, pb_uni}), 0);
    load_ta = 1; tick(); idle();
    check("ta_sat", 32'(tentos_a), 3);
    check("erro_clean", 32'(erro_cmd), 0);

    // Game over freezes loads but not clears
    valor_mao = 5; load_pa = 1; tick(); idle();
    check("pa_5", 32'(pontos_a), 5);
    fim_jogo = 1;
    load_pa = 1; load_tb = 1; tick(); idle();
    check("fim_pa", 32'(pontos_a), 5);
    check("fim_tb", 32'(tentos_b), 0);
    clear_ta = 1; tick(); idle();
    check("fim_clr_ta", 32'(tentos_a), 0);
    check("fim_clr_flag", 32'(ta_igual3), 0);
    fim_jogo = 0;

    // Simultaneous point loads: both execute, erro sticks
    valor_mao = 1; load_pa = 1; load_pb = 1; tick(); idle();
    check("dual_pa", 32'(pontos_a), 6);
    check("dual_pb", 32'(pontos_b), 1);
    check("dual_erro", 32'(erro_cmd), 1);
    load_tb = 1; tick(); idle();
    check("sticky_tb", 32'(tentos_b), 1);
    check("sticky_erro", 32'(erro_cmd), 1);
    tick();
    check("sticky_erro2", 32'(erro_cmd), 1);

    // Reset clears erro; load+clear on the same register sets it
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    check("erro_rst", 32'(erro_cmd), 0);
    load_tb = 1; clear_tb = 1; tick(); idle();
    check("lc_tb", 32'(tentos_b), 0);
    check("lc_erro", 32'(erro_cmd), 1);

    // Reset; simultaneous tento loads also flag
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    load_ta = 1; load_tb = 1; tick(); idle();
    check("tt_ta", 32'(tentos_a), 1);
    check("tt_tb", 32'(tentos_b), 1);
    check("tt_erro", 32'(erro_cmd), 1);

    // Held strobe applies every cycle
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    valor_mao = 4; load_pb = 1; tick(); tick(); idle();
    check("held_pb", 32'(pontos_b), 8);
    check("held_erro", 32'(erro_cmd), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/placar_datapath.md
Name: placar_datapath

Overview:
- Score datapath for the truco match; the command-receiving end of the score controller's load/clear interface.
- Holds hand points (0..12) and tentos (0..3) for teams A and B, and executes the controller's load/clear strobes.
- Returns the equality flags the controller branches on: a_igual12, b_igual12, ta_igual3, tb_igual3.
- Also drives registered BCD digits of both scores for the display block.

Parameters:
PONTOS_MAX, 12, hand-point target; points saturate here and the *_igual12 flags compare against it
TENTOS_MAX, 3, tento target; tentos saturate here and the t*_igual3 flags compare against it

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
load_pa  in  1  add valor_mao to team A points
clear_pa  in  1  zero team A points
load_ta  in  1  add one tento to team A
clear_ta  in  1  zero team A tentos
load_pb  in  1  add valor_mao to team B points
clear_pb  in  1  zero team B points
load_tb  in  1  add one tento to team B
clear_tb  in  1  zero team B tentos
fim_jogo  in  1  game over; while high, all load_* are ignored
valor_mao  in  4  points of the current hand; 0 is treated as 1; values above 12 are treated as 12
pontos_a  out  4  team A points
pontos_b  out  4  team B points
tentos_a  out  2  team A tentos
tentos_b  out  2  team B tentos
a_igual12  out  1  pontos_a == PONTOS_MAX
b_igual12  out  1  pontos_b == PONTOS_MAX
ta_igual3  out  1  tentos_a == TENTOS_MAX
tb_igual3  out  1  tentos_b == TENTOS_MAX
pa_dez, pa_uni  out  4 each  BCD tens and units of pontos_a
pb_dez, pb_uni  out  4 each  BCD tens and units of pontos_b
erro_cmd  out  1  sticky flag for an illegal command combination

Behaviour:
Reset:
- All registers, flags, BCD digits and erro_cmd go to 0 asynchronously when reset is high.
- Reset may be asserted at any cycle; it overrides any strobe in flight.

Points register (per team), evaluated each rising edge:
- clear_x high: next value is 0; clear has priority over load.
- Else load_x high and fim_jogo low: next = min(pontos + v, PONTOS_MAX).
  - v is valor_mao after the 0->1 and >12->12 mapping.
  - The sum is computed in 5 bits so no wrap occurs.
- Else: hold.

Tentos register (per team):
- Same priority rule: clear, then load (only when fim_jogo is low), then hold.
- Load adds exactly 1 and saturates at TENTOS_MAX, so a load at 3 leaves 3.

Strobe independence:
- Strobes to different registers act in the same cycle. Example: clear_pa + clear_pb + load_ta together clear both scores and add a tento in one edge.

Flags:
- Registered, computed from each register's next value.
- A flag is therefore valid in the first cycle after the load edge, which is the controller's compare state. Zero extra latency relative to the register contents.

BCD digits:
- Registered from the next value, so they are coherent with pontos_* in the same cycle.
- Values 10..12 give dez = 1, uni = value - 10.

erro_cmd:
- Set on any edge where one of these is true:
  - load_pa & load_pb
  - load_ta & load_tb
  - load_x & clear_x on the same register
- The offending command still executes under the rules above.
- Stays set until reset.

Single-cycle strobes:
- The datapath acts once per cycle a strobe is high; a strobe held N cycles is applied N times.

Test Plan:
- Reset high mid-operation with pontos_a = 7 -> all outputs 0 immediately (asynchronously); they stay 0 for the first edge after reset is released with no strobes.
- valor_mao = 3; load_pa pulsed 4 times -> pontos_a = 3, 6, 9, 12; a_igual12 = 1 the cycle after the 4th pulse; pa_dez = 1, pa_uni = 2.
- pontos_b = 10, valor_mao = 6, load_pb -> pontos_b = 12 (saturated), b_igual12 = 1; then valor_mao = 0, load_pb -> stays 12.
- Same-cycle clear_pa + clear_pb + load_ta with pontos_a = 12, tentos_a = 2 -> pontos_a = 0, pontos_b = 0, tentos_a = 3, ta_igual3 = 1, a_igual12 = 0.
- fim_jogo = 1 with load_pa and load_tb pulsed -> no change; clear_ta still zeroes tentos_a.
- load_pa + load_pb in the same cycle with valor_mao = 1 -> both scores increment, erro_cmd = 1 and stays 1 through later legal commands until reset.
